// File: rtl/voice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voice_pkg
// Purpose  : Shared types and constants for the PDM voice-record block.
// Revision : 1.0  initial release
// ============================================================================
package voice_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARM    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/mic_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : mic_clk_gen
// Purpose  : Divides clk down to the PDM microphone clock and flags the last
//            clk cycle of every micClk high phase as the data sample point.
// Revision : 1.0  initial release
// ============================================================================
module mic_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic micClk,
  output logic sample_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Half-period counter; micClk starts low and is parked at 0 while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      micClk <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      micClk <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      micClk <= ~micClk;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Last cycle of a high phase: the mic output has been stable longest here
  assign sample_stb = en && micClk && (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/record_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : record_ctrl
// Purpose  : Record-button driven PDM capture. Warms the microphone up, packs
//            PDM bits MSB-first into 32-bit words and writes them to a buffer.
// Revision : 1.0  initial release
// ============================================================================
module record_ctrl
  import voice_pkg::*;
#(
  parameter  int CLK_DIV = 25,
  parameter  int WARMUP  = 1024,
  parameter  int DEPTH   = 2048,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              micData,
  output logic              micClk,
  output logic              micLRSel,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [5:0]        BIT_LAST  = 6'(WORD_W - 1);

  rec_state_t state, state_n;

  logic rec_s1, rec_s2, rec_d;
  logic mic_s1, mic_s;
  logic press, stb, mic_en;
  logic last_bit, leave_now;
  logic stop_flag, word_end;
  logic [WORD_W-2:0] shift;   // bits already received; the newest bit completes the word
  logic [5:0]        bit_cnt;
  logic [WARM_W-1:0] warm_cnt;

  assign micLRSel = 1'b0;
  assign mic_en   = (state != IDLE);
  assign press    = rec_s2 & ~rec_d;
  assign last_bit = stb && (bit_cnt == BIT_LAST);
  // A stop with nothing of the current word shifted needs no wait for a word end
  assign leave_now = (stop_flag || press) && (bit_cnt == '0) && !word_end;

  mic_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_mic_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (mic_en),
    .micClk     (micClk),
    .sample_stb (stb)
  );

  // Two-flop synchronizers for the button and mic data, plus button edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_s1 <= 1'b0;
      rec_s2 <= 1'b0;
      rec_d  <= 1'b0;
      mic_s1 <= 1'b0;
      mic_s  <= 1'b0;
    end else begin
      rec_s1 <= record;
      rec_s2 <= rec_s1;
      rec_d  <= rec_s2;
      mic_s1 <= micData;
      mic_s  <= mic_s1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (press) state_n = WARM;
      end
      WARM: begin
        if (press)                               state_n = IDLE;
        else if (stb && (warm_cnt == WARM_LAST)) state_n = CAPTURE;
      end
      CAPTURE: begin
        // word_end is the cycle where a completed word is written (or dropped)
        if (word_end) begin
          if (stop_flag || press || (ram_wr && (word_count == LAST_WORD)))
            state_n = DONE;
        end else if (leave_now) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture datapath: warm-up count, bit packing, buffer write and bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      word_count <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      warm_cnt   <= '0;
      stop_flag  <= 1'b0;
      word_end   <= 1'b0;
    end else begin
      ram_wr   <= 1'b0;
      word_end <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            ram_addr   <= '0;
            word_count <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            warm_cnt   <= '0;
            stop_flag  <= 1'b0;
          end
        end
        WARM: begin
          if (stb && !press) warm_cnt <= warm_cnt + WARM_W'(1);
        end
        CAPTURE: begin
          if (press) stop_flag <= 1'b1;
          if (word_end) begin
            bit_cnt <= '0;
            if (ram_wr) begin
              ram_addr   <= ram_addr + ADDR_W'(1);
              word_count <= word_count + (ADDR_W + 1)'(1);
            end
          end else if (stb && !leave_now) begin
            shift   <= {shift[WORD_W-3:0], mic_s};
            bit_cnt <= bit_cnt + 6'd1;
            if (last_bit) begin
              word_end <= 1'b1;
              // A stop requested before this word's final bit drops the word
              if (!stop_flag) begin
                ram_wr   <= 1'b1;
                ram_data <= {shift, mic_s};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_record_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_record_ctrl
// Purpose  : Directed self-checking bench for record_ctrl
//            (CLK_DIV=2, WARMUP=4, DEPTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_record_ctrl;

  localparam int CLK_DIV = 2;
  localparam int WARMUP  = 4;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic record  = 1'b0;
  logic micData = 1'b0;
  logic micClk, micLRSel, ram_wr, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic [ADDR_W:0]   word_count;

  int n_vec  = 0;
  int n_err  = 0;
  int wr_n   = 0;
  int done_n = 0;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [31:0]       wr_data [64];
  time busy_rise    = 0;
  time mc_rise      = 0;
  time mc_rise_prev = 0;
  time first_gap    = 0;

  always #5 clk = ~clk;

  record_ctrl #(
    .CLK_DIV (CLK_DIV),
    .WARMUP  (WARMUP),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .record     (record),
    .micData    (micData),
    .micClk     (micClk),
    .micLRSel   (micLRSel),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  // Log every buffer write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_wr) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = ram_addr;
        wr_data[wr_n] = ram_data;
      end
      wr_n++;
    end
    if (done) done_n++;
  end

  always @(posedge busy) busy_rise = $time;

  // Time of micClk rises; the first rise after busy rises gives the start latency
  always @(posedge micClk) begin
    if (mc_rise < busy_rise) first_gap = $time - busy_rise;
    mc_rise_prev = mc_rise;
    mc_rise      = $time;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2 ms, required finish");
    $fatal(1, "watchdog expired");
  end

  // Data bit for strobe number s (1-based, counted from the press)
  function automatic logic pat(input bit alt, input int s);
    if (!alt)        return 1'b1;
    if (s <= WARMUP) return 1'b0;
    return ((s - WARMUP - 1) % 2) == 0;
  endfunction

  // Wait for the next micClk fall, or for the block to go idle
  task automatic wait_fall(output bit stopped);
    logic prev;
    bit   seen;
    prev    = micClk;
    stopped = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        stopped = 1'b1;
        seen    = 1'b1;
      end else if (prev && !micClk) begin
        seen = 1'b1;
      end
      prev = micClk;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL mic_fall_timeout: no micClk fall in 20 cycles, required one");
      stopped = 1'b1;
    end
  endtask

  // Optionally press record, then feed one data bit per strobe; optionally
  // press again so that the press lands in the cycle of strobe press_at+1
  task automatic drive(input bit start, input int n_falls, input int press_at, input bit alt);
    bit stopped;
    if (start) begin
      @(posedge clk); #1;
      record = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      record = 1'b0;
    end
    for (int c = 0; c < n_falls; c++) begin
      micData = pat(alt, c + 1);
      if (c == press_at) begin
        @(posedge clk); #1;
        record = 1'b1;
      end
      wait_fall(stopped);
      if (stopped) break;
    end
    record = 1'b0;
  endtask

  task automatic do_reset();
    record  = 1'b0;
    micData = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({micClk, micLRSel, ram_wr, busy, done, ram_addr, ram_data, word_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got clk=%b lr=%b wr=%b busy=%b done=%b addr=%h data=%h wc=%h, required all 0",
               micClk, micLRSel, ram_wr, busy, done, ram_addr, ram_data, word_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if ({micClk, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got micClk=%b busy=%b, required 0 0", micClk, busy);
    end
  endtask

  task automatic test_warm_ones();
    int w0;
    w0 = wr_n;
    drive(1'b1, 5, -1, 1'b0);
    n_vec++;
    if (wr_n != w0) begin
      n_err++; $display("FAIL warm_no_write: got %0d writes, required 0", wr_n - w0);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL warm_busy: got %b, required 1", busy);
    end
    n_vec++;
    if (first_gap != 20) begin
      n_err++; $display("FAIL first_rise: got %0t ns after start, required 20", first_gap);
    end
    n_vec++;
    if (mc_rise - mc_rise_prev != 40) begin
      n_err++; $display("FAIL mic_period: got %0t ns, required 40", mc_rise - mc_rise_prev);
    end
    drive(1'b0, 31, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wr_n - w0 != 1) begin
      n_err++; $display("FAIL ones_write_count: got %0d, required 1", wr_n - w0);
    end
    n_vec++;
    if (wr_addr[w0] !== 3'd0) begin
      n_err++; $display("FAIL ones_addr: got %0d, required 0", wr_addr[w0]);
    end
    n_vec++;
    if (wr_data[w0] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL ones_data: got %h, required ffffffff", wr_data[w0]);
    end
    n_vec++;
    if (ram_data !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL ones_data_hold: got %h, required ffffffff", ram_data);
    end
    do_reset();
  endtask

  task automatic test_full();
    int w0, d0;
    w0 = wr_n;
    d0 = done_n;
    drive(1'b1, 300, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wr_n - w0 != 8) begin
      n_err++; $display("FAIL full_write_count: got %0d, required 8", wr_n - w0);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (wr_addr[w0+i] !== 3'(i) || wr_data[w0+i] !== 32'hAAAA_AAAA) begin
        n_err++;
        $display("FAIL full_write_%0d: got addr=%0d data=%h, required addr=%0d data=aaaaaaaa",
                 i, wr_addr[w0+i], wr_data[w0+i], i);
      end
    end
    n_vec++;
    if (done_n - d0 != 1) begin
      n_err++; $display("FAIL full_done: got %0d pulses, required 1", done_n - d0);
    end
    n_vec++;
    if (word_count !== 4'd8) begin
      n_err++; $display("FAIL full_word_count: got %0d, required 8", word_count);
    end
    n_vec++;
    if ({busy, ram_addr} !== 4'b0) begin
      n_err++; $display("FAIL full_idle: got busy=%b addr=%0d, required 0 0", busy, ram_addr);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_n;
    drive(1'b1, 21, -1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({micClk, ram_wr, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL midreset_ctrl: got micClk=%b wr=%b busy=%b done=%b, required 0 0 0 0",
               micClk, ram_wr, busy, done);
    end
    n_vec++;
    if (ram_data !== 32'h0) begin
      n_err++; $display("FAIL midreset_data: got %h, required 0", ram_data);
    end
    n_vec++;
    if ({ram_addr, word_count} !== '0) begin
      n_err++; $display("FAIL midreset_count: got addr=%0d wc=%0d, required 0 0", ram_addr, word_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_vec++;
    if (wr_n != w0 || busy !== 1'b0 || micClk !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_release: got %0d writes busy=%b micClk=%b, required 0 0 0",
               wr_n - w0, busy, micClk);
    end
  endtask

  task automatic test_stop_partial();
    int w0, d0;
    w0 = wr_n;
    d0 = done_n;
    drive(1'b1, 300, WARMUP + 96 + 10, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wr_n - w0 != 3) begin
      n_err++; $display("FAIL stop_write_count: got %0d, required 3", wr_n - w0);
    end
    n_vec++;
    if (wr_addr[w0+2] !== 3'd2) begin
      n_err++; $display("FAIL stop_last_addr: got %0d, required 2", wr_addr[w0+2]);
    end
    n_vec++;
    if (done_n - d0 != 1) begin
      n_err++; $display("FAIL stop_done: got %0d pulses, required 1", done_n - d0);
    end
    n_vec++;
    if (word_count !== 4'd3 || busy !== 1'b0) begin
      n_err++; $display("FAIL stop_word_count: got wc=%0d busy=%b, required 3 0", word_count, busy);
    end
  endtask

  task automatic test_warm_abort();
    int w0, d0, hi;
    w0 = wr_n;
    d0 = done_n;
    hi = 0;
    drive(1'b1, 10, 2, 1'b1);
    n_vec++;
    if (busy !== 1'b0 || word_count !== 4'd0) begin
      n_err++; $display("FAIL abort_state: got busy=%b wc=%0d, required 0 0", busy, word_count);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (micClk) hi++;
    end
    n_vec++;
    if (hi != 0) begin
      n_err++; $display("FAIL abort_micclk: got %0d high cycles, required 0", hi);
    end
    n_vec++;
    if (done_n != d0 || wr_n != w0) begin
      n_err++; $display("FAIL abort_no_done: got done=%0d writes=%0d, required 0 0", done_n - d0, wr_n - w0);
    end
  endtask

  task automatic test_stop_on_last();
    int w0, d0;
    w0 = wr_n;
    d0 = done_n;
    drive(1'b1, 100, WARMUP + 31, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wr_n - w0 != 1) begin
      n_err++; $display("FAIL last_write_count: got %0d, required 1", wr_n - w0);
    end
    n_vec++;
    if (wr_addr[w0] !== 3'd0 || wr_data[w0] !== 32'hAAAA_AAAA) begin
      n_err++; $display("FAIL last_write: got addr=%0d data=%h, required 0 aaaaaaaa", wr_addr[w0], wr_data[w0]);
    end
    n_vec++;
    if (done_n - d0 != 1) begin
      n_err++; $display("FAIL last_done: got %0d pulses, required 1", done_n - d0);
    end
    n_vec++;
    if (word_count !== 4'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL last_word_count: got wc=%0d busy=%b, required 1 0", word_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_warm_ones();
    test_full();
    test_reset_mid();
    test_stop_partial();
    test_warm_abort();
    test_stop_on_last();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
